// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping core.
// Contents: controller state encoding, adjust field-select values and the
// default BCD digit limits used by the counters.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StPaused = 2'd0,
    StRun    = 2'd1,
    StAdjust = 2'd2
  } state_e;

  // Values of the adjust field select input.
  localparam logic SelMin = 1'b0;
  localparam logic SelSec = 1'b1;

  // Default limits of a two-digit field (00..59).
  localparam int unsigned DefMaxTens = 5;
  localparam int unsigned DefMaxOnes = 9;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter, 00..MAX_TENS MAX_ONES (00..59 by default).
// Ports:
//   master      clock, rising edge
//   rst         synchronous active-high reset to 00
//   inc         one-cycle increment enable
//   tens, ones  registered BCD digits
//   carry       combinational: inc is high while the count is at its maximum
module bcd_mod60
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_TENS = DefMaxTens,
  parameter int unsigned MAX_ONES = DefMaxOnes
) (
  input  logic       master,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [3:0] TensMax = 4'(MAX_TENS);
  localparam logic [3:0] OnesMax = 4'(MAX_ONES);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == TensMax) && (ones_q == OnesMax);
  assign carry  = inc && at_max;

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc) begin
      if (ones_q == OnesMax) begin
        ones_d = 4'd0;
        tens_d = (tens_q == TensMax) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge master) begin
    if (rst) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping core: MM:SS BCD count with run, pause and adjust.
// Build option: define STOPWATCH_BLINK_EN to blink the selected field while
// adjusting; otherwise blank is held at 4'b0000 and tick_fast is unused.
// Ports:
//   master                  clock, rising edge
//   rst                     synchronous active-high reset
//   tick_1hz/2hz/fast       one-cycle count / adjust / blink enables
//   pause_p                 one-cycle pause/resume pulse
//   adj, sel                adjust level; field select (0 minutes, 1 seconds)
//   min_*, sec_*            registered BCD digits
//   running                 high while counting
//   wrap                    one-cycle pulse on 59:59 -> 00:00 while counting
//   blank                   digit blank mask {min_tens, min_ones, sec_tens, sec_ones}
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_TENS = DefMaxTens,
  parameter int unsigned MAX_ONES = DefMaxOnes
) (
  input  logic       master,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_fast,
  input  logic       pause_p,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       wrap,
  output logic [3:0] blank
);

  state_e state_q, state_d;
  logic   resume_run_q, resume_run_d;
  logic   running_q;
  logic   wrap_q, wrap_d;
  logic   sec_inc, sec_carry;
  logic   min_inc, min_carry;

  bcd_mod60 #(
    .MAX_TENS(MAX_TENS),
    .MAX_ONES(MAX_ONES)
  ) u_sec (
    .master(master),
    .rst   (rst),
    .inc   (sec_inc),
    .tens  (sec_tens),
    .ones  (sec_ones),
    .carry (sec_carry)
  );

  bcd_mod60 #(
    .MAX_TENS(MAX_TENS),
    .MAX_ONES(MAX_ONES)
  ) u_min (
    .master(master),
    .rst   (rst),
    .inc   (min_inc),
    .tens  (min_tens),
    .ones  (min_ones),
    .carry (min_carry)
  );

  // Increments are decided from the registered state, so a tick that
  // coincides with a state change still lands under the old state's rules.
  always_comb begin
    state_d      = state_q;
    resume_run_d = resume_run_q;
    sec_inc      = 1'b0;
    min_inc      = 1'b0;
    wrap_d       = 1'b0;
    unique case (state_q)
      StPaused: begin
        if (adj) begin
          state_d      = StAdjust;
          resume_run_d = 1'b0;
        end else if (pause_p) begin
          state_d = StRun;
        end
      end
      StRun: begin
        sec_inc = tick_1hz;
        min_inc = sec_carry;
        // Minutes only carry when seconds carry, so this is 59:59 -> 00:00.
        wrap_d  = min_carry;
        if (adj) begin
          state_d      = StAdjust;
          resume_run_d = 1'b1;
        end else if (pause_p) begin
          state_d = StPaused;
        end
      end
      StAdjust: begin
        sec_inc = tick_2hz && (sel == SelSec);
        min_inc = tick_2hz && (sel == SelMin);
        if (!adj) begin
          state_d = resume_run_q ? StRun : StPaused;
        end
      end
      default: state_d = StPaused;
    endcase
  end

  always_ff @(posedge master) begin
    if (rst) begin
      state_q      <= StPaused;
      resume_run_q <= 1'b0;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      resume_run_q <= resume_run_d;
      running_q    <= (state_d == StRun);
      wrap_q       <= wrap_d;
    end
  end

  assign running = running_q;
  assign wrap    = wrap_q;

`ifdef STOPWATCH_BLINK_EN
  logic       phase_q, phase_d;
  logic [3:0] blank_q, blank_d;

  always_comb begin
    phase_d = phase_q;
    if (state_q != StAdjust && state_d == StAdjust) begin
      phase_d = 1'b0;
    end else if (state_q == StAdjust && tick_fast) begin
      phase_d = ~phase_q;
    end
    blank_d = 4'b0000;
    if (state_d == StAdjust && phase_d) begin
      blank_d = (sel == SelSec) ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge master) begin
    if (rst) begin
      phase_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      phase_q <= phase_d;
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  logic unused_tick_fast;
  assign unused_tick_fast = tick_fast;
  assign blank            = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed sequences followed by random
// stimulus, with expected outputs from a minutes/seconds arithmetic model
// queued per clock and compared by an independent monitor.
module tb_stopwatch_core;

  logic       master = 1'b0;
  logic       rst = 1'b0, tick_1hz = 1'b0, tick_2hz = 1'b0, tick_fast = 1'b0;
  logic       pause_p = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic       running, wrap;

  stopwatch_core dut (
    .master   (master),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .tick_fast(tick_fast),
    .pause_p  (pause_p),
    .adj      (adj),
    .sel      (sel),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .wrap     (wrap),
    .blank    (blank)
  );

  always #5 master = ~master;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        wrap;
    logic [3:0]  blank;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: whole minutes and seconds as integers.
  localparam int ModePaused = 0, ModeRun = 1, ModeAdjust = 2;
  int m_mode = ModePaused;
  int m_mm = 0, m_ss = 0;
  bit m_resume = 0, m_phase = 0, m_wrap = 0;

  function automatic exp_t model_expect();
    exp_t e;
    e.digits  = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
    e.running = (m_mode == ModeRun);
    e.wrap    = m_wrap;
`ifdef STOPWATCH_BLINK_EN
    e.blank = (m_mode == ModeAdjust && m_phase) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
`else
    e.blank = 4'b0000;
`endif
    return e;
  endfunction

  task automatic model_step();
    int old_mode;
    old_mode = m_mode;
    m_wrap   = 0;
    if (rst) begin
      m_mode = ModePaused; m_resume = 0; m_mm = 0; m_ss = 0; m_phase = 0;
    end else begin
      if (old_mode == ModeRun && tick_1hz) begin
        m_ss = m_ss + 1;
        if (m_ss == 60) begin
          m_ss = 0;
          m_mm = m_mm + 1;
          if (m_mm == 60) begin
            m_mm   = 0;
            m_wrap = 1;
          end
        end
      end
      if (old_mode == ModeAdjust) begin
        if (tick_2hz) begin
          if (sel) m_ss = (m_ss + 1) % 60;
          else     m_mm = (m_mm + 1) % 60;
        end
        if (tick_fast) m_phase = !m_phase;
        if (!adj) m_mode = m_resume ? ModeRun : ModePaused;
      end else if (adj) begin
        m_mode   = ModeAdjust;
        m_resume = (old_mode == ModeRun);
        m_phase  = 0;
      end else if (pause_p) begin
        m_mode = (old_mode == ModeRun) ? ModePaused : ModeRun;
      end
    end
  endtask

  // Drive one cycle of pulse inputs; adj and sel are levels set by the caller.
  task automatic cycle(input bit r, input bit t1, input bit t2, input bit tf, input bit p);
    rst = r; tick_1hz = t1; tick_2hz = t2; tick_fast = tf; pause_p = p;
    @(posedge master);
    model_step();
    sb_q.push_back(model_expect());
    #1;
  endtask

  task automatic check_field(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  exp_t mon_e;
  always @(negedge master) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_field("digits", {min_tens, min_ones, sec_tens, sec_ones}, mon_e.digits);
      check_field("running", 16'(running), 16'(mon_e.running));
      check_field("wrap", 16'(wrap), 16'(mon_e.wrap));
      check_field("blank", 16'(blank), 16'(mon_e.blank));
    end
  end

  initial begin
    // Reset, run 5 s, pause, ticks ignored.
    repeat (2) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 0);

    // Preload 00:59 from PAUSED, then run into the minute carry.
    adj = 1; sel = 1;
    cycle(0, 0, 0, 0, 0);
    repeat (54) cycle(0, 0, 1, 0, 0);
    adj = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);

    // Adjust from RUN up to 59:59, resume, and wrap.
    adj = 1; sel = 0;
    cycle(0, 0, 0, 0, 0);
    repeat (58) cycle(0, 0, 1, 0, 0);
    sel = 1;
    repeat (59) cycle(0, 0, 1, 0, 0);
    adj = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Run to 00:58, adjust seconds past 59, ticks ignored, resume.
    repeat (58) cycle(0, 1, 0, 0, 0);
    adj = 1; sel = 1;
    cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 1, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 1);
    adj = 0;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);

    // Minutes adjust from PAUSED: 61 ticks is +1 minute.
    cycle(0, 0, 0, 0, 1);
    adj = 1; sel = 0;
    cycle(0, 0, 0, 0, 0);
    repeat (61) cycle(0, 0, 1, 0, 0);
    adj = 0;
    cycle(0, 0, 0, 0, 0);

    // Simultaneous events.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    repeat (10) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    adj = 1; sel = 1;
    cycle(0, 0, 0, 0, 0);
    adj = 0;
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1);
    adj = 1;
    cycle(0, 1, 0, 0, 0);

    // Blink, field switch, then reset mid-adjust.
    repeat (4) begin
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0);
    end
    sel = 0;
    repeat (3) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    adj = 0;
    cycle(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) adj = !adj;
      if ($urandom_range(0, 9) == 0) sel = !sel;
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
    end

    // Drain with a bounded wait.
    repeat (3) @(posedge master);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
